muldiv_ctrl: RTL and testbench
==============================

// Module: muldiv_ctrl
// PURPOSE
// Iterative RV32M multiply/divide sequencer in the EX stage. Accepts one M-extension op per start
// and runs a shift-add multiplier or restoring divider, one bit per cycle. Drives muldiv_busy into
// the hazard unit (stalls IF/ID/EX) and returns a one-cycle done pulse with the result and dest reg.
// PARAMETERS
// XLEN  32  operand/result width; iteration count = XLEN
// PORTS
// clk         in   1     core clock
// rst_n       in   1     asynchronous active-low reset
// start       in   1     EX holds a valid M-op this cycle
// op          in   3     funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
// rs1_data    in   XLEN  operand A (multiplicand/dividend)
// rs2_data    in   XLEN  operand B (multiplier/divisor)
// rd_in       in   5     destination register of the op
// kill        in   1     pipeline flush; abort in-flight op
// busy        out  1     to hazard unit muldiv_busy
// done        out  1     result valid, single-cycle pulse
// result      out  XLEN  result, valid when done=1
// rd_out      out  5     destination register, valid when done=1
// BEHAVIOUR
// - Reset (async, rst_n=0): state=IDLE, busy=0, done=0, result=0, rd_out=0, internal regs cleared. Applies mid-op; no done follows.
// - States: IDLE, CALC, FIX, DONE. The DONE state counts as idle for accepting start.
// - Accept: start=1 and state in {IDLE, DONE} and kill=0. Latch operand magnitudes, sign flags, op and rd_in.
// - start while in CALC or FIX: ignored (EX is stalled, so this cannot occur legally).
// - Normal path: accept at cycle T -> CALC T+1..T+XLEN (counter 0..XLEN-1) -> FIX T+XLEN+1 (conditional two's-complement negate, hi/lo select) -> DONE T+XLEN+2.
// - busy: combinational. High in accept cycle T and while state is CALC or FIX. Low in DONE. Hazard unit stalls from cycle T onward.
// - done=1 only in the DONE state. result/rd_out are registered and held until the next accept.
// - Multiply: 2*XLEN product over operand magnitudes. Signedness: MUL/MULH s*s, MULHSU s*u, MULHU u*u. MUL returns low half; others return high half.
// - Divide: restoring, unsigned magnitudes.
//   - Quotient sign = sA^sB.
//   - Remainder sign = sA.
//   - Signedness applies only for DIV/REM.
// - Special cases detected at accept; they skip CALC/FIX and go straight to DONE at T+1:
//   - divisor=0: quotient = all-ones; remainder = rs1_data.
//   - signed overflow (A=1<<(XLEN-1), B=-1): quotient = A; remainder = 0.
// - kill: has priority over start and over every state. Next state = IDLE; busy drops the next cycle; no done is generated; result is unchanged.
// - Counter width = clog2(XLEN). No wrap: CALC exits at count XLEN-1.
// CONFIGURATION
// - MULDIV_FAST_MUL_EN defined: MUL/MULH/MULHSU/MULHU use a single-cycle signed (XLEN+1)x(XLEN+1) multiply at accept. Go to DONE at T+1. Divide is unchanged.
// - Undefined: all multiplies take the iterative path, done at T+XLEN+2.
// TESTING (XLEN=32, MULDIV_FAST_MUL_EN undefined unless noted)
// 1. MUL 7 * 0xFFFFFFFD at T:
//    - result 0xFFFFFFEB, done only at T+34.
//    - busy=1 at T..T+33, busy=0 at T+34.
// 2. Multiply high halves:
//    - MULH 0x80000000,0x80000000 -> 0x40000000
//    - MULHU 0xFFFFFFFF,0xFFFFFFFF -> 0xFFFFFFFE
//    - MULHSU 0xFFFFFFFF,0xFFFFFFFF -> 0xFFFFFFFF
// 3. Division signs:
//    - DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF
//    - DIVU 100/7 -> 14; REMU -> 2
// 4. Special cases, each with done at T+1:
//    - DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5
//    - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0
// 5. kill at T+10 of a DIV:
//    - busy=0 at T+11, no done pulse ever.
//    - New start at T+11 completes normally with the correct rd_out.
// 6. Back-to-back and reset:
//    - start in the DONE cycle is accepted; the second result is correct.
//    - rst_n low at T+5 forces busy=0, done=0 asynchronously.
//    - With MULDIV_FAST_MUL_EN: MUL 7*-3 gives done at T+1.

Source files
------------

// File: rtl/muldiv_ctrl.sv
// Iterative RV32M multiply/divide sequencer: shift-add multiplier and restoring divider, one bit per cycle.
// Define MULDIV_FAST_MUL_EN to complete multiplies in a single cycle at accept; divides stay iterative.
module muldiv_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      rd_in,
    input  logic            kill,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);
    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [XLEN-1:0] r_hi;
    logic [XLEN-1:0] r_lo;
    logic [XLEN-1:0] r_b;
    logic [2:0]      r_op;
    logic [4:0]      r_rd;
    logic            r_neg;
    logic [XLEN-1:0] r_result;
    logic [4:0]      r_rd_out;

    logic            w_accept;
    logic            w_is_div;
    logic            w_a_signed;
    logic            w_b_signed;
    logic            w_sa;
    logic            w_sb;
    logic [XLEN-1:0] w_mag_a;
    logic [XLEN-1:0] w_mag_b;
    logic            w_div0;
    logic            w_ovf;
    logic [XLEN-1:0] w_spec_res;
    logic [XLEN:0]   w_add;
    logic [XLEN:0]   w_trial;
    logic [2*XLEN-1:0] w_prod;
    logic [2*XLEN-1:0] w_prod_fix;
    logic [XLEN-1:0] w_div_sel;
    logic [XLEN-1:0] w_div_fix;
    logic [XLEN-1:0] w_fix_res;

    assign w_accept   = start && !kill && (r_state == S_IDLE || r_state == S_DONE);
    assign w_is_div   = op[2];
    // MUL treated as s*s: the low half is identical for any signedness.
    assign w_a_signed = (op == 3'b000) || (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
    assign w_b_signed = (op == 3'b000) || (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
    assign w_sa       = w_a_signed & rs1_data[XLEN-1];
    assign w_sb       = w_b_signed & rs2_data[XLEN-1];
    assign w_mag_a    = w_sa ? -rs1_data : rs1_data;
    assign w_mag_b    = w_sb ? -rs2_data : rs2_data;
    assign w_div0     = (rs2_data == '0);
    assign w_ovf      = !op[0] && (rs1_data == INT_MIN) && (rs2_data == '1);
    assign w_spec_res = w_div0 ? (op[1] ? rs1_data : '1) : (op[1] ? '0 : INT_MIN);

    assign w_add   = {1'b0, r_hi} + {1'b0, (r_lo[0] ? r_b : '0)};
    // Top bit of the trial difference set means the divisor did not fit.
    assign w_trial = {r_hi, r_lo[XLEN-1]} - {1'b0, r_b};

    assign w_prod     = {r_hi, r_lo};
    assign w_prod_fix = r_neg ? -w_prod : w_prod;
    assign w_div_sel  = r_op[1] ? r_hi : r_lo;
    assign w_div_fix  = r_neg ? -w_div_sel : w_div_sel;
    assign w_fix_res  = r_op[2] ? w_div_fix :
                        (r_op[1:0] == 2'b00) ? w_prod_fix[XLEN-1:0] : w_prod_fix[2*XLEN-1:XLEN];

`ifdef MULDIV_FAST_MUL_EN
    logic signed [XLEN:0]     w_fa;
    logic signed [XLEN:0]     w_fb;
    logic signed [2*XLEN+1:0] w_fprod;
    logic [XLEN-1:0]          w_fast_res;

    assign w_fa       = $signed({w_sa, rs1_data});
    assign w_fb       = $signed({w_sb, rs2_data});
    assign w_fprod    = w_fa * w_fb;
    assign w_fast_res = (op[1:0] == 2'b00) ? w_fprod[XLEN-1:0] : w_fprod[2*XLEN-1:XLEN];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_rd     <= '0;
            r_neg    <= 1'b0;
            r_result <= '0;
            r_rd_out <= '0;
        end else if (kill) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_accept) begin
                        r_op  <= op;
                        r_rd  <= rd_in;
                        r_cnt <= '0;
                        r_hi  <= '0;
                        r_b   <= w_is_div ? w_mag_b : w_mag_a;
                        r_lo  <= w_is_div ? w_mag_a : w_mag_b;
                        r_neg <= (w_is_div && op[1]) ? w_sa : (w_sa ^ w_sb);
                        if (w_is_div && (w_div0 || w_ovf)) begin
                            r_result <= w_spec_res;
                            r_rd_out <= rd_in;
                            r_state  <= S_DONE;
                        end
`ifdef MULDIV_FAST_MUL_EN
                        else if (!w_is_div) begin
                            r_result <= w_fast_res;
                            r_rd_out <= rd_in;
                            r_state  <= S_DONE;
                        end
`endif
                        else begin
                            r_state <= S_CALC;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_CALC: begin
                    if (r_op[2]) begin
                        if (!w_trial[XLEN]) begin
                            r_hi <= w_trial[XLEN-1:0];
                            r_lo <= {r_lo[XLEN-2:0], 1'b1};
                        end else begin
                            r_hi <= {r_hi[XLEN-2:0], r_lo[XLEN-1]};
                            r_lo <= {r_lo[XLEN-2:0], 1'b0};
                        end
                    end else begin
                        r_hi <= w_add[XLEN:1];
                        r_lo <= {w_add[0], r_lo[XLEN-1:1]};
                    end
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_LAST) r_state <= S_FIX;
                end
                S_FIX: begin
                    r_result <= w_fix_res;
                    r_rd_out <= r_rd;
                    r_state  <= S_DONE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy   = w_accept || (r_state == S_CALC) || (r_state == S_FIX);
    assign done   = (r_state == S_DONE);
    assign result = r_result;
    assign rd_out = r_rd_out;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: arithmetic results, latency, busy/done timing, kill, back-to-back and reset.
module tb_muldiv_ctrl;
    localparam logic [2:0] OP_MUL = 3'b000, OP_MULH = 3'b001, OP_MULHSU = 3'b010, OP_MULHU = 3'b011;
    localparam logic [2:0] OP_DIV = 3'b100, OP_DIVU = 3'b101, OP_REM = 3'b110, OP_REMU = 3'b111;
    localparam int DIV_LAT = 34;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 34;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = '0;
    logic [31:0] rs1_data = '0;
    logic [31:0] rs2_data = '0;
    logic [4:0]  rd_in = '0;
    logic        kill = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int checks = 0;
    int failures = 0;

    muldiv_ctrl #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_in(rd_in), .kill(kill),
        .busy(busy), .done(done), .result(result), .rd_out(rd_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Drive an op in the current cycle (called just after a falling edge); busy must rise at once.
    task automatic launch(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        op = o; rs1_data = a; rs2_data = b; rd_in = rd; start = 1'b1;
        #1;
        chk("busy_accept", {31'b0, busy}, 32'd1);
    endtask

    // Wait for done (bounded); returns in the done cycle with start low.
    task automatic finish_op(input string tag, input int lat, input logic [31:0] exp_res, input logic [4:0] exp_rd);
        int  n = 0;
        bit  seen = 0;
        bit  busy_ok = 1;
        while (!seen && n < 60) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            n++;
            if (done === 1'b1) seen = 1;
            else if (busy !== 1'b1) busy_ok = 0;
        end
        chk({tag, "_done_seen"}, {31'b0, seen}, 32'd1);
        chk({tag, "_latency"}, n, lat);
        chk({tag, "_busy_run"}, {31'b0, busy_ok}, 32'd1);
        chk({tag, "_busy_at_done"}, {31'b0, busy}, 32'd0);
        chk({tag, "_result"}, result, exp_res);
        chk({tag, "_rd_out"}, {27'b0, rd_out}, {27'b0, exp_rd});
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input int lat, input logic [31:0] exp_res);
        @(negedge clk);
        launch(o, a, b, rd);
        finish_op(tag, lat, exp_res, rd);
        $display("op=%0d a=%h b=%h -> result=%h rd=%0d (%s)", o, a, b, result, rd_out, tag);
    endtask

    initial begin
        int pulses;
        #1;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_rd_out", {27'b0, rd_out}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_op("mul_neg", OP_MUL, 32'd7, 32'hFFFFFFFD, 5'd5, MUL_LAT, 32'hFFFFFFEB);
        @(negedge clk); #1;
        chk("done_single_pulse", {31'b0, done}, 32'd0);

        run_op("mulh_min", OP_MULH, 32'h80000000, 32'h80000000, 5'd1, MUL_LAT, 32'h40000000);
        run_op("mulhu_max", OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, MUL_LAT, 32'hFFFFFFFE);
        run_op("mulhsu", OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, MUL_LAT, 32'hFFFFFFFF);

        run_op("div_neg", OP_DIV, 32'hFFFFFFF9, 32'd2, 5'd10, DIV_LAT, 32'hFFFFFFFD);
        run_op("rem_neg", OP_REM, 32'hFFFFFFF9, 32'd2, 5'd11, DIV_LAT, 32'hFFFFFFFF);
        run_op("divu", OP_DIVU, 32'd100, 32'd7, 5'd12, DIV_LAT, 32'd14);
        run_op("remu", OP_REMU, 32'd100, 32'd7, 5'd13, DIV_LAT, 32'd2);

        run_op("div_by0", OP_DIV, 32'd5, 32'd0, 5'd14, 1, 32'hFFFFFFFF);
        run_op("rem_by0", OP_REM, 32'd5, 32'd0, 5'd15, 1, 32'd5);
        run_op("divu_by0", OP_DIVU, 32'd9, 32'd0, 5'd16, 1, 32'hFFFFFFFF);
        run_op("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 5'd17, 1, 32'h80000000);
        run_op("rem_ovf", OP_REM, 32'h80000000, 32'hFFFFFFFF, 5'd18, 1, 32'd0);

        // Kill in CALC at T+10, restart at T+11.
        @(negedge clk);
        launch(OP_DIV, 32'd1000, 32'd3, 5'd7);
        repeat (10) begin
            @(negedge clk);
            start = 1'b0;
        end
        kill = 1'b1;
        #1;
        chk("kill_busy_T10", {31'b0, busy}, 32'd1);
        @(negedge clk);
        kill = 1'b0;
        #1;
        chk("kill_busy_T11", {31'b0, busy}, 32'd0);
        chk("kill_no_done", {31'b0, done}, 32'd0);
        chk("kill_result_held", result, 32'd0);
        launch(OP_DIVU, 32'd100, 32'd7, 5'd9);
        finish_op("after_kill", DIV_LAT, 32'd14, 5'd9);
        $display("kill then restart -> result=%h rd=%0d", result, rd_out);

        // Back-to-back: new start in the DONE cycle.
        @(negedge clk);
        launch(OP_REMU, 32'd100, 32'd7, 5'd3);
        finish_op("b2b_first", DIV_LAT, 32'd2, 5'd3);
        launch(OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4);
        finish_op("b2b_second", MUL_LAT, 32'hFFFFFFFE, 5'd4);
        launch(OP_DIV, 32'd5, 32'd0, 5'd6);
        finish_op("b2b_third", 1, 32'hFFFFFFFF, 5'd6);
        $display("back-to-back -> result=%h rd=%0d", result, rd_out);

        // Asynchronous reset mid-op at T+5.
        @(negedge clk);
        launch(OP_DIV, 32'd100, 32'd7, 5'd8);
        repeat (5) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        chk("areset_busy", {31'b0, busy}, 32'd0);
        chk("areset_done", {31'b0, done}, 32'd0);
        chk("areset_result", result, 32'd0);
        chk("areset_rd_out", {27'b0, rd_out}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) pulses++;
        end
        chk("areset_no_done_after", pulses, 32'd0);
        $display("reset mid-op -> busy=%0b done=%0b result=%h", busy, done, result);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
